// File: rtl/avg_iir_tdm.sv
// Multi-channel TDM exponential-averaging IIR; AVG_IIR_TDM_ROUND_EN selects round-half-up output.
// Latency: 2 advancing edges from accept to o_valid, 1 sample/cycle throughput.
// Backpressure: o_ready = !o_valid || i_ready; both stages hold while stalled.
module avg_iir_tdm #(
  parameter int DATA_W    = 24,
  parameter int N_CH      = 8,
  parameter int FRAC_BITS = 8,
  parameter int MAX_SHIFT = 15,
  localparam int ACC_W    = DATA_W + FRAC_BITS,
  localparam int SH_W     = $clog2(MAX_SHIFT + 1),
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CH_W:0]     i_ch,
  input  logic [SH_W-1:0]   i_shift,
  input  logic              i_clr,
  input  logic [CH_W-1:0]   i_clr_ch,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_drop
);

  localparam bit NEED_CLAMP = ((2 ** SH_W) - 1) > MAX_SHIFT;

  // Per-channel state
  logic signed [ACC_W-1:0] acc_q [N_CH];
  logic signed [ACC_W-1:0] acc_d [N_CH];
  logic [N_CH-1:0]         primed_q, primed_d;

  // S1 registers
  logic                    s1_vld_q, s1_vld_d;
  logic                    s1_bad_q, s1_bad_d;
  logic signed [DATA_W-1:0] s1_x_q, s1_x_d;
  logic [CH_W-1:0]         s1_ch_q, s1_ch_d;
  logic [SH_W-1:0]         s1_k_q, s1_k_d;
  logic                    s1_primed_q, s1_primed_d;
  logic signed [ACC_W-1:0] s1_acc_q, s1_acc_d;

  // S2 output registers
  logic                    o_valid_q, o_valid_d;
  logic [DATA_W-1:0]       o_data_q, o_data_d;
  logic [CH_W-1:0]         o_ch_q, o_ch_d;
  logic                    o_drop_q, o_drop_d;

  logic                    advance, accept, in_bad, wb, fwd, clr_in;
  logic [CH_W-1:0]         in_ch;
  logic [SH_W-1:0]         k_in;
  logic signed [ACC_W-1:0] rd_acc;
  logic                    rd_primed;

  logic signed [ACC_W-1:0] xs;
  logic signed [ACC_W:0]   diff, step, sum;
  logic signed [ACC_W-1:0] acc_next;
  logic [DATA_W-1:0]       y;

  generate
    if (NEED_CLAMP) begin : g_clamp
      assign k_in = (i_shift > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : i_shift;
    end else begin : g_noclamp
      assign k_in = i_shift;
    end
  endgenerate

  always_comb begin
    advance   = !o_valid_q || i_ready;
    accept    = i_valid && advance;
    in_bad    = i_ch >= (CH_W + 1)'(N_CH);
    in_ch     = i_ch[CH_W-1:0];
    wb        = advance && s1_vld_q && !s1_bad_q;
    fwd       = wb && (s1_ch_q == in_ch);
    clr_in    = i_clr && (i_clr_ch == in_ch);
    rd_acc    = '0;
    rd_primed = 1'b0;
    if (!in_bad) begin
      rd_acc    = acc_q[in_ch];
      rd_primed = primed_q[in_ch];
    end
  end

  // Filter update from S1; unprimed channels (and k=0) snap to the input.
  always_comb begin
    xs       = {s1_x_q, {FRAC_BITS{1'b0}}};
    diff     = {xs[ACC_W-1], xs} - {s1_acc_q[ACC_W-1], s1_acc_q};
    step     = diff >>> s1_k_q;
    sum      = {s1_acc_q[ACC_W-1], s1_acc_q} + step;
    acc_next = s1_primed_q ? ACC_W'(sum) : xs;
  end

`ifdef AVG_IIR_TDM_ROUND_EN
  localparam logic [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (FRAC_BITS - 1);
  logic signed [ACC_W:0]  rnd_sum, rnd_sh;
  logic signed [DATA_W:0] rnd_y;

  always_comb begin
    rnd_sum = {acc_next[ACC_W-1], acc_next} + RND_HALF;
    rnd_sh  = rnd_sum >>> FRAC_BITS;
    rnd_y   = (DATA_W + 1)'(rnd_sh);
    if (!rnd_y[DATA_W] && rnd_y[DATA_W-1]) begin
      y = {1'b0, {(DATA_W - 1){1'b1}}};
    end else begin
      y = rnd_y[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    y = acc_next[ACC_W-1:FRAC_BITS];
  end
`endif

  // A clear always beats a writeback landing on the same channel and edge.
  always_comb begin
    acc_d    = acc_q;
    primed_d = primed_q;
    if (wb) begin
      acc_d[s1_ch_q]    = acc_next;
      primed_d[s1_ch_q] = 1'b1;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (i_clr && (i_clr_ch == CH_W'(i))) begin
        primed_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_bad_d    = s1_bad_q;
    s1_x_d      = s1_x_q;
    s1_ch_d     = s1_ch_q;
    s1_k_d      = s1_k_q;
    s1_primed_d = s1_primed_q;
    s1_acc_d    = s1_acc_q;
    if (advance) begin
      s1_vld_d    = accept;
      s1_bad_d    = in_bad;
      s1_x_d      = i_data;
      s1_ch_d     = in_ch;
      s1_k_d      = k_in;
      s1_acc_d    = fwd ? acc_next : rd_acc;
      s1_primed_d = (fwd || rd_primed) && !clr_in;
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_ch_d    = o_ch_q;
    o_drop_d  = 1'b0;
    if (advance) begin
      o_valid_d = s1_vld_q && !s1_bad_q;
      o_drop_d  = s1_vld_q && s1_bad_q;
      if (wb) begin
        o_data_d = y;
        o_ch_d   = s1_ch_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
      end
      primed_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_bad_q    <= 1'b0;
      s1_x_q      <= '0;
      s1_ch_q     <= '0;
      s1_k_q      <= '0;
      s1_primed_q <= 1'b0;
      s1_acc_q    <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_ch_q      <= '0;
      o_drop_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      primed_q    <= primed_d;
      s1_vld_q    <= s1_vld_d;
      s1_bad_q    <= s1_bad_d;
      s1_x_q      <= s1_x_d;
      s1_ch_q     <= s1_ch_d;
      s1_k_q      <= s1_k_d;
      s1_primed_q <= s1_primed_d;
      s1_acc_q    <= s1_acc_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_ch_q      <= o_ch_d;
      o_drop_q    <= o_drop_d;
    end
  end

  assign o_ready = advance;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_ch    = o_ch_q;
  assign o_drop  = o_drop_q;

endmodule

// File: tb/tb_avg_iir_tdm.sv
// Directed bench for avg_iir_tdm with hand-computed expected outputs.
module tb_avg_iir_tdm;
  localparam int DATA_W    = 16;
  localparam int N_CH      = 8;
  localparam int FRAC_BITS = 8;
  localparam int MAX_SHIFT = 12;
  localparam int SH_W      = 4;
  localparam int CH_W      = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic [DATA_W-1:0]        i_data = '0;
  logic [CH_W:0]            i_ch = '0;
  logic [SH_W-1:0]          i_shift = '0;
  logic                     i_clr = 1'b0;
  logic [CH_W-1:0]          i_clr_ch = '0;
  logic                     o_valid;
  logic                     i_ready = 1'b1;
  logic signed [DATA_W-1:0] o_data;
  logic [CH_W-1:0]          o_ch;
  logic                     o_drop;

  avg_iir_tdm #(
    .DATA_W(DATA_W), .N_CH(N_CH), .FRAC_BITS(FRAC_BITS), .MAX_SHIFT(MAX_SHIFT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_ch(i_ch), .i_shift(i_shift), .i_clr(i_clr),
    .i_clr_ch(i_clr_ch), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_ch(o_ch), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int got_d[$], got_c[$], out_cyc[$], acc_cyc[$], exp_d[$], exp_c[$];
  int drops = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) begin
        got_d.push_back(int'(o_data));
        got_c.push_back(int'(o_ch));
        out_cyc.push_back(cyc);
      end
      if (o_drop) drops++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int ch, input int x, input int k);
    bit done = 1'b0;
    i_valid = 1'b1;
    i_ch    = 4'(ch);
    i_data  = 16'(x);
    i_shift = 4'(k);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (o_ready) begin
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_out(input int ch, input int d);
    exp_c.push_back(ch);
    exp_d.push_back(d);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_d.delete(); got_c.delete(); out_cyc.delete(); acc_cyc.delete();
    exp_d.delete(); exp_c.delete();
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_ch%0d", tag, i), got_c[i], exp_c[i]);
    end
    clear_q();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_clr = 1'b0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_ch", int'(o_ch), 0);
    chk("rst_drop", int'(o_drop), 0);
    chk("rst_ready", int'(o_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_q();
    drops = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    // Step response, k=2, with latency check
    do_reset();
    send(0, 0, 2);
    send(0, 1000, 2);
    send(0, 1000, 2);
    send(0, 1000, 2);
    expect_out(0, 0);
    expect_out(0, 250);
`ifdef AVG_IIR_TDM_ROUND_EN
    expect_out(0, 438);
`else
    expect_out(0, 437);
`endif
    expect_out(0, 578);
    settle();
    chk("t1_lat_count", out_cyc.size(), 4);
    for (int i = 0; i < 4 && i < out_cyc.size() && i < acc_cyc.size(); i++)
      chk($sformatf("t1_latency%0d", i), out_cyc[i] - acc_cyc[i], 2);
    compare("t1");

    // Interleaved channels, k=1
    do_reset();
    send(0, -100, 1);
    send(1, 40, 1);
    send(0, 100, 1);
    send(1, 40, 1);
    expect_out(0, -100);
    expect_out(1, 40);
    expect_out(0, 0);
    expect_out(1, 40);
    settle();
    compare("t2_ilv");

    // Back-to-back same channel exercises forwarding
    do_reset();
    send(0, -100, 1);
    send(0, 100, 1);
    expect_out(0, -100);
    expect_out(0, 0);
    settle();
    compare("t2_fwd");

    // Downstream stall with a third sample waiting
    do_reset();
    i_ready = 1'b0;
    send(2, 11, 1);
    send(3, 22, 1);
    i_valid = 1'b1; i_ch = 4'd4; i_data = 16'd33; i_shift = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_ready_low", int'(o_ready), 0);
      chk("t3_valid_held", int'(o_valid), 1);
      chk("t3_data_held", int'(o_data), 11);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(4, 33, 1);
    expect_out(2, 11);
    expect_out(3, 22);
    expect_out(4, 33);
    settle();
    compare("t3");

    // Channel clear behaviour
    do_reset();
    send(3, 500, 3);
    expect_out(3, 500);
    settle();
    i_clr = 1'b1; i_clr_ch = 3'd3;
    @(posedge clk);
    #1;
    i_clr = 1'b0;
    send(3, 800, 3);
    expect_out(3, 800);
    settle();
    i_clr = 1'b1; i_clr_ch = 3'd3;
    send(3, 200, 3);
    i_clr = 1'b0;
    expect_out(3, 200);
    settle();
    send(5, 300, 3);
    i_clr = 1'b1; i_clr_ch = 3'd5;
    @(posedge clk);
    #1;
    i_clr = 1'b0;
    send(5, 900, 3);
    expect_out(5, 300);
    expect_out(5, 900);
    settle();
    compare("t4");

    // Invalid channel drop and shift clamp
    do_reset();
    send(0, 100, 4);
    expect_out(0, 100);
    settle();
    send(8, 5000, 4);
    settle();
    chk("t5_drop_once", drops, 1);
    send(0, 100, 4);
    expect_out(0, 100);
    send(2, 0, 4);
    send(2, 4096, 15);
    expect_out(2, 0);
    expect_out(2, 1);
    settle();
    chk("t5_drop_total", drops, 1);
    compare("t5");

    // Reset with samples in flight
    do_reset();
    send(0, 1000, 1);
    expect_out(0, 1000);
    settle();
    compare("t6a");
    i_ready = 1'b0;
    send(0, -2000, 1);
    send(1, 3000, 1);
    chk("t6_inflight_valid", int'(o_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(o_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    send(0, 777, 1);
    send(1, -5, 1);
    expect_out(0, 777);
    expect_out(1, -5);
    settle();
    compare("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
